vid_timing_gen: RTL

//   Transmit-side video source: generates 640x480@60 raster timing (hsync/vsync/de) on clk25.

---
 rtl/vid_timing_pkg.sv | 36 +++
 rtl/vid_colorbar.sv | 32 +++
 rtl/vid_timing_gen.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vid_timing_pkg.sv
// rtl/vid_timing_pkg.sv - 640x480@60 timing constants, FSM state type and colour-bar palette
package vid_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W = 10;

  localparam logic HS_POL = 1'b0;
  localparam logic VS_POL = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

endpackage

// File: rtl/vid_colorbar.sv
// rtl/vid_colorbar.sv - eight vertical colour bars selected from the horizontal counter
// Only built when COLORBAR_EN is defined.
`ifdef COLORBAR_EN
module vid_colorbar #(
  parameter int BAR_W = vid_timing_pkg::H_ACTIVE / 8
) (
  input  logic [vid_timing_pkg::CNT_W-1:0] h,
  output logic [23:0]                      rgb
);
  import vid_timing_pkg::*;

  localparam logic [CNT_W-1:0] E1 = CNT_W'(1 * BAR_W);
  localparam logic [CNT_W-1:0] E2 = CNT_W'(2 * BAR_W);
  localparam logic [CNT_W-1:0] E3 = CNT_W'(3 * BAR_W);
  localparam logic [CNT_W-1:0] E4 = CNT_W'(4 * BAR_W);
  localparam logic [CNT_W-1:0] E5 = CNT_W'(5 * BAR_W);
  localparam logic [CNT_W-1:0] E6 = CNT_W'(6 * BAR_W);
  localparam logic [CNT_W-1:0] E7 = CNT_W'(7 * BAR_W);

  always_comb begin
    if      (h < E1) rgb = BAR_WHITE;
    else if (h < E2) rgb = BAR_YELLOW;
    else if (h < E3) rgb = BAR_CYAN;
    else if (h < E4) rgb = BAR_GREEN;
    else if (h < E5) rgb = BAR_MAGENTA;
    else if (h < E6) rgb = BAR_RED;
    else if (h < E7) rgb = BAR_BLUE;
    else             rgb = BAR_BLACK;
  end

endmodule
`endif

// File: rtl/vid_timing_gen.sv
// rtl/vid_timing_gen.sv - 640x480 raster timing generator with registered RGB/sync output
// Optional COLORBAR_EN adds pattern_sel and an internal colour-bar source.
module vid_timing_gen #(
  parameter int   H_ACTIVE = vid_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vid_timing_pkg::H_FP,
  parameter int   H_SYNC   = vid_timing_pkg::H_SYNC,
  parameter int   H_BP     = vid_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vid_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vid_timing_pkg::V_FP,
  parameter int   V_SYNC   = vid_timing_pkg::V_SYNC,
  parameter int   V_BP     = vid_timing_pkg::V_BP,
  parameter logic HS_POL   = vid_timing_pkg::HS_POL,
  parameter logic VS_POL   = vid_timing_pkg::VS_POL
) (
  input  logic        clk25,
  input  logic        rstin,
  input  logic        enable,
`ifdef COLORBAR_EN
  input  logic        pattern_sel,
`endif
  input  logic [23:0] pix_rgb,
  output logic        pix_req,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start,
  output logic        busy
);
  import vid_timing_pkg::*;

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] h, v;
  logic             running, h_wrap, frame_end, active;
  logic [23:0]      px_nxt, rgb_q;

  assign running   = (state != ST_IDLE);
  assign h_wrap    = (h == H_LAST);
  assign frame_end = h_wrap && (v == V_LAST);
  assign active    = running && (h < H_ACT) && (v < V_ACT);

  always_ff @(posedge clk25 or posedge rstin) begin
    if (rstin) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // DRAIN keeps the raster going so a frame is never cut short.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_RUN;
      ST_RUN: begin
        if (frame_end)    state_nxt = enable ? ST_RUN : ST_IDLE;
        else if (!enable) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (enable)         state_nxt = ST_RUN;
        else if (frame_end) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk25 or posedge rstin) begin
    if (rstin || !running) begin
      h <= '0;
      v <= '0;
    end else if (h_wrap) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

`ifdef COLORBAR_EN
  logic        pat_q;
  logic [23:0] bar_rgb;

  always_ff @(posedge clk25 or posedge rstin) begin
    if (rstin)                      pat_q <= 1'b0;
    else if (!running || frame_end) pat_q <= pattern_sel;
  end

  vid_colorbar #(.BAR_W(H_ACTIVE / 8)) u_colorbar (
    .h   (h),
    .rgb (bar_rgb)
  );

  assign pix_req = active && !pat_q;
  assign px_nxt  = pat_q ? bar_rgb : pix_rgb;
`else
  assign pix_req = active;
  assign px_nxt  = pix_rgb;
`endif

  always_ff @(posedge clk25 or posedge rstin) begin
    if (rstin) begin
      de          <= 1'b0;
      rgb_q       <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      de          <= active;
      rgb_q       <= active ? px_nxt : '0;
      hsync       <= (running && h >= H_SS && h < H_SE) ? HS_POL : ~HS_POL;
      vsync       <= (running && v >= V_SS && v < V_SE) ? VS_POL : ~VS_POL;
      frame_start <= running && (h == '0) && (v == '0);
    end
  end

  assign {red, green, blue} = rgb_q;
  assign hcount = h;
  assign vcount = v;
  assign busy   = running;

endmodule
